// File: rtl/apb_requester_arbiter.sv
// apb_requester_arbiter: shares one APB bus between N_REQ local requesters.
// Round-robin arbitration, then a SETUP/ACCESS sequence on the APB requester
// side; read data and error status are returned to the granted requester.
// Optional feature macro: APB_TIMEOUT_EN (aborts an ACCESS phase that waits
// TIMEOUT_CYCLES cycles without pready and returns an error response).
module apb_requester_arbiter #(
   parameter int N_REQ          = 4,
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                          pclk_i,
   input  logic                          presetn_i,
   input  logic [N_REQ-1:0]              req_valid_i,
   input  logic [N_REQ-1:0]              req_write_i,
   input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr_i,
   input  logic [N_REQ*DATA_WIDTH-1:0]   req_wdata_i,
   output logic [N_REQ-1:0]              req_ready_o,
   output logic [N_REQ-1:0]              rsp_valid_o,
   output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
   output logic                          rsp_err_o,
   output logic [ADDR_WIDTH-1:0]         paddr_o,
   output logic                          psel_o,
   output logic                          penable_o,
   output logic                          pwrite_o,
   output logic [DATA_WIDTH-1:0]         pwdata_o,
   input  logic                          pready_i,
   input  logic [DATA_WIDTH-1:0]         prdata_i,
   input  logic                          pslverr_i
);

   localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int PW1 = PW + 1;

   // Elaboration-time guard on the supported configuration range.
   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("apb_requester_arbiter: unsupported N_REQ or TIMEOUT_CYCLES");
   end

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

   typedef struct packed {
      logic                  write;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } apb_req_t;

   state_t                 state_q, state_d;
   logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]          gnt_q, gnt_d;
   apb_req_t               req_q, req_d, arb_req;
   logic                   psel_q, psel_d;
   logic                   penable_q, penable_d;
   logic [N_REQ-1:0]       req_ready_q, req_ready_d;
   logic [N_REQ-1:0]       rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
   logic                   rsp_err_q, rsp_err_d;
   logic                   arb_hit, launch;
   logic [PW-1:0]          arb_idx;
   logic [PW1-1:0]         cand;

`ifdef APB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0]          cnt_q, cnt_d;
`endif

   // Round-robin pick: first active requester at or after rr_ptr, wrapping.
   always_comb begin
      arb_hit = 1'b0;
      arb_idx = '0;
      cand    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + PW1'(k);
         if (cand >= PW1'(N_REQ)) cand = cand - PW1'(N_REQ);
         if (!arb_hit && req_valid_i[cand[PW-1:0]]) begin
            arb_hit = 1'b1;
            arb_idx = cand[PW-1:0];
         end
      end
   end

   // Request fields of the current arbitration winner.
   always_comb begin
      arb_req.write = req_write_i[arb_idx];
      arb_req.addr  = req_addr_i[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
      arb_req.wdata = req_wdata_i[arb_idx*DATA_WIDTH +: DATA_WIDTH];
   end

   // Next-state and registered-output logic for the APB sequencer.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      gnt_d       = gnt_q;
      req_d       = req_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      req_ready_d = '0;
      rsp_valid_d = '0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = 1'b0;
      launch      = 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         IDLE: launch = arb_hit;
         SETUP: begin
            penable_d = 1'b1;
            rr_ptr_d  = (gnt_q == PW'(N_REQ - 1)) ? '0 : gnt_q + PW'(1);
            state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
            cnt_d     = '0;
`endif
         end
         ACCESS: begin
            if (pready_i) begin
               rsp_rdata_d        = req_q.write ? '0 : prdata_i;
               rsp_err_d          = pslverr_i;
               rsp_valid_d[gnt_q] = 1'b1;
               // Back-to-back: a pending request goes straight to SETUP.
               launch = arb_hit;
               if (!arb_hit) begin
                  psel_d    = 1'b0;
                  penable_d = 1'b0;
                  state_d   = IDLE;
               end
            end
`ifdef APB_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               // This is the limit-th wait cycle: abort with an error response.
               rsp_rdata_d        = '0;
               rsp_err_d          = 1'b1;
               rsp_valid_d[gnt_q] = 1'b1;
               psel_d             = 1'b0;
               penable_d          = 1'b0;
               state_d            = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`endif
         end
         default: state_d = IDLE;
      endcase

      if (launch) begin
         gnt_d                = arb_idx;
         req_d                = arb_req;
         psel_d               = 1'b1;
         penable_d            = 1'b0;
         req_ready_d[arb_idx] = 1'b1;
         state_d              = SETUP;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge pclk_i) begin
      if (!presetn_i) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         gnt_q       <= '0;
         req_q       <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         req_ready_q <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         gnt_q       <= gnt_d;
         req_q       <= req_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign req_ready_o = req_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
   assign paddr_o     = req_q.addr;
   assign pwrite_o    = req_q.write;
   assign pwdata_o    = req_q.wdata;
   assign psel_o      = psel_q;
   assign penable_o   = penable_q;

endmodule

// File: tb/tb_apb_requester_arbiter.sv
// Scoreboard bench for apb_requester_arbiter: stimulus pushes expected grants
// and responses; negedge monitors pop and compare when the DUT presents them.
module tb_apb_requester_arbiter;

   logic          pclk = 1'b0;
   logic          presetn;
   logic [3:0]    req_valid, req_write, req_ready_o, rsp_valid_o;
   logic [31:0]   req_addr;
   logic [127:0]  req_wdata;
   logic [31:0]   rsp_rdata_o, pwdata_o, prdata;
   logic          rsp_err_o, psel_o, penable_o, pwrite_o, pready, pslverr;
   logic [7:0]    paddr_o;

   // Completer model controls
   int            ws_cfg;
   logic          err_en;
   logic [7:0]    err_addr;
   logic [7:0]    wcnt;
   logic [31:0]   mem [256];

   int checks = 0;
   int errors = 0;

   typedef struct {int idx; logic [31:0] data; logic err;} rsp_t;
   rsp_t rsp_q[$];
   int   gnt_q[$];
   rsp_t mon_e;
   int   mon_g;

   apb_requester_arbiter #(.N_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
      .pclk_i(pclk), .presetn_i(presetn),
      .req_valid_i(req_valid), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
      .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o),
      .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
      .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
   );

   always #5 pclk = ~pclk;

   // Completer: memory preset to {C0FFEE, addr}, configurable wait states.
   assign pready  = psel_o && penable_o && (wcnt == ws_cfg[7:0]);
   assign prdata  = mem[paddr_o];
   assign pslverr = err_en && pready && (paddr_o == err_addr);

   always @(posedge pclk) begin
      if (!presetn) begin
         for (int i = 0; i < 256; i++) mem[i] <= {24'hC0FFEE, 8'(i)};
         wcnt <= '0;
      end else begin
         if (psel_o && penable_o && !pready) wcnt <= wcnt + 8'd1;
         else wcnt <= '0;
         if (psel_o && penable_o && pready && pwrite_o) mem[paddr_o] <= pwdata_o;
      end
   end

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // Monitor: grants and responses against the scoreboard queues.
   always @(negedge pclk) begin
      if (req_ready_o != 4'b0) begin
         if (gnt_q.size() == 0) chk("grant_unexpected", req_ready_o, 0);
         else begin
            mon_g = gnt_q.pop_front();
            chk("grant", req_ready_o, 4'b1 << mon_g);
         end
      end
      if (rsp_valid_o != 4'b0) begin
         if (rsp_q.size() == 0) chk("rsp_unexpected", rsp_valid_o, 0);
         else begin
            mon_e = rsp_q.pop_front();
            chk("rsp_valid", rsp_valid_o, 4'b1 << mon_e.idx);
            chk("rsp_rdata", rsp_rdata_o, mon_e.data);
            chk("rsp_err", rsp_err_o, mon_e.err);
         end
      end
   end

   task automatic post(input int idx, input logic wr, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err, input bit push_rsp);
      rsp_t e;
      req_valid[idx] = 1'b1;
      req_write[idx] = wr;
      req_addr[idx*8 +: 8] = a;
      req_wdata[idx*32 +: 32] = d;
      gnt_q.push_back(idx);
      if (push_rsp) begin
         e.idx = idx; e.data = exp_rd; e.err = exp_err;
         rsp_q.push_back(e);
      end
   endtask

   // Drop each requester's valid right after its req_ready pulse.
   task automatic serve(input int n);
      int got = 0;
      int budget = 0;
      logic [3:0] rr;
      while (got < n && budget < 200) begin
         @(negedge pclk);
         rr = req_ready_o;
         if (rr != 4'b0) got++;
         @(posedge pclk); #1;
         req_valid = req_valid & ~rr;
         budget++;
      end
      chk("serve_grants", got, n);
   endtask

   task automatic wait_idle();
      int b = 0;
      @(negedge pclk);
      while (psel_o && b < 300) begin
         b++;
         @(negedge pclk);
      end
      chk("idle_reached", psel_o, 0);
      @(posedge pclk); #1;
   endtask

   task automatic do_reset();
      presetn = 1'b0;
      @(posedge pclk); #1;
      @(posedge pclk); #1;
      presetn = 1'b1;
   endtask

   initial begin
      int n;
      presetn = 1'b0;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      ws_cfg = 0; err_en = 1'b0; err_addr = '0;
      repeat (3) @(posedge pclk);
      #1;
      // Reset state
      @(negedge pclk);
      chk("rst_req_ready", req_ready_o, 0);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      chk("rst_psel_penable", {psel_o, penable_o}, 2'b00);
      chk("rst_paddr", paddr_o, 0);
      chk("rst_pwdata", pwdata_o, 0);
      chk("rst_pwrite", pwrite_o, 0);
      chk("rst_rsp_rdata", rsp_rdata_o, 0);
      chk("rst_rsp_err", rsp_err_o, 0);
      @(posedge pclk); #1;
      presetn = 1'b1;

      // Single write from requester 1, cycle-exact latency
      post(1, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
      @(negedge pclk);
      chk("t1_T_ready", req_ready_o, 0);
      @(posedge pclk); #1;
      @(negedge pclk);
      chk("t1_T1_ready", req_ready_o, 4'b0010);
      chk("t1_T1_setup", {psel_o, penable_o}, 2'b10);
      @(posedge pclk); #1;
      req_valid = '0;
      @(negedge pclk);
      chk("t1_T2_access", {psel_o, penable_o}, 2'b11);
      chk("t1_T2_paddr", paddr_o, 8'h10);
      chk("t1_T2_pwdata", pwdata_o, 32'hDEADBEEF);
      chk("t1_T2_pwrite", pwrite_o, 1'b1);
      @(posedge pclk); #1;
      @(negedge pclk);
      chk("t1_T3_rsp_valid", rsp_valid_o, 4'b0010);
      chk("t1_T3_idle", psel_o, 1'b0);
      @(posedge pclk); #1;
      // Read it back
      post(1, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
      serve(1);
      wait_idle();

      // All four reading continuously: grants 0,1,2,3,0 back-to-back
      do_reset();
      post(0, 1'b0, 8'h40, 32'h0, 32'hC0FFEE40, 1'b0, 1'b1);
      post(1, 1'b0, 8'h44, 32'h0, 32'hC0FFEE44, 1'b0, 1'b1);
      post(2, 1'b0, 8'h48, 32'h0, 32'hC0FFEE48, 1'b0, 1'b1);
      post(3, 1'b0, 8'h4C, 32'h0, 32'hC0FFEE4C, 1'b0, 1'b1);
      gnt_q.push_back(0);
      begin
         rsp_t e;
         e.idx = 0; e.data = 32'hC0FFEE40; e.err = 1'b0;
         rsp_q.push_back(e);
      end
      n = 0;
      @(negedge pclk);
      while (req_ready_o == 4'b0 && n < 20) begin
         n++;
         @(negedge pclk);
      end
      chk("t2_first_grant_seen", req_ready_o != 4'b0, 1'b1);
      for (int c = 0; c < 9; c++) begin
         if (c > 0) @(negedge pclk);
         chk("t2_psel_held", psel_o, 1'b1);
         chk("t2_grant_slot", req_ready_o != 4'b0, (c % 2) == 0);
      end
      @(posedge pclk); #1;
      req_valid = '0;
      @(negedge pclk);
      chk("t2_last_access", {psel_o, penable_o}, 2'b11);
      wait_idle();

      // Read with three wait states
      ws_cfg = 3;
      post(2, 1'b0, 8'h30, 32'h0, 32'hC0FFEE30, 1'b0, 1'b1);
      serve(1);
      for (int k = 0; k < 4; k++) begin
         @(negedge pclk);
         chk("t3_access_hold", {psel_o, penable_o}, 2'b11);
         chk("t3_paddr_hold", paddr_o, 8'h30);
         chk("t3_no_early_rsp", rsp_valid_o, 0);
         @(posedge pclk); #1;
      end
      @(negedge pclk);
      chk("t3_rsp_after_pready", rsp_valid_o, 4'b0100);
      chk("t3_rdata", rsp_rdata_o, 32'hC0FFEE30);
      @(posedge pclk); #1;
      @(negedge pclk);
      chk("t3_rsp_one_cycle", rsp_valid_o, 0);
      @(posedge pclk); #1;
      ws_cfg = 0;

      // Completer error on 0xA0, then clean read of 0x20
      err_en = 1'b1; err_addr = 8'hA0;
      post(0, 1'b0, 8'hA0, 32'h0, 32'hC0FFEEA0, 1'b1, 1'b1);
      serve(1);
      wait_idle();
      post(0, 1'b0, 8'h20, 32'h0, 32'hC0FFEE20, 1'b0, 1'b1);
      serve(1);
      wait_idle();
      err_en = 1'b0;

      // Reset during ACCESS of requester 2; no response for it afterwards
      ws_cfg = 5;
      post(2, 1'b0, 8'h60, 32'h0, 32'h0, 1'b0, 1'b0);
      serve(1);
      @(negedge pclk);
      chk("t5_in_access", penable_o, 1'b1);
      @(posedge pclk); #1;
      presetn = 1'b0;
      @(posedge pclk); #1;
      presetn = 1'b1;
      @(negedge pclk);
      chk("t5_rst_bus", {psel_o, penable_o}, 2'b00);
      chk("t5_rst_ready", req_ready_o, 0);
      chk("t5_rst_rsp", rsp_valid_o, 0);
      chk("t5_rst_paddr", paddr_o, 0);
      @(posedge pclk); #1;
      ws_cfg = 0;
      // Pointer back at 0: requester 1 must beat requester 3
      post(1, 1'b0, 8'h64, 32'h0, 32'hC0FFEE64, 1'b0, 1'b1);
      post(3, 1'b0, 8'h6C, 32'h0, 32'hC0FFEE6C, 1'b0, 1'b1);
      serve(2);
      wait_idle();

`ifdef APB_TIMEOUT_EN
      // Stuck completer: abort after 16 ACCESS cycles
      ws_cfg = 100;
      post(0, 1'b0, 8'h50, 32'h0, 32'h0, 1'b1, 1'b1);
      serve(1);
      n = 0;
      @(negedge pclk);
      while (penable_o && n < 100) begin
         n++;
         @(posedge pclk); #1;
         @(negedge pclk);
      end
      chk("tmo_access_cycles", n, 16);
      chk("tmo_psel_drop", psel_o, 1'b0);
      @(posedge pclk); #1;
      // pready on the 16th ACCESS cycle completes normally
      ws_cfg = 15;
      post(0, 1'b0, 8'h54, 32'h0, 32'hC0FFEE54, 1'b0, 1'b1);
      serve(1);
      wait_idle();
      ws_cfg = 0;
`endif

      repeat (3) @(posedge pclk);
      #1;
      chk("grant_queue_drained", gnt_q.size(), 0);
      chk("rsp_queue_drained", rsp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
